// File: rtl/mult32x32_arbiter.sv
// Two-port arbiter in front of a shared start/busy multiplier; returns the product tagged with owner.
// Define MULT32X32_ARB_RR_EN for round-robin arbitration, otherwise port 0 has fixed priority.
module mult32x32_arbiter #(
    parameter int unsigned OP_W    = 32,
    parameter int unsigned TIMEOUT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [OP_W-1:0]   req0_a,
    input  logic [OP_W-1:0]   req0_b,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [OP_W-1:0]   req1_a,
    input  logic [OP_W-1:0]   req1_b,
    output logic              req1_ready,
    output logic              mult_start,
    output logic [OP_W-1:0]   mult_a,
    output logic [OP_W-1:0]   mult_b,
    input  logic              mult_busy,
    input  logic [2*OP_W-1:0] mult_product,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [2*OP_W-1:0] rsp_product,
    output logic              rsp_err
);

    typedef enum logic [2:0] {StIdle, StStart, StWaitBusy, StRun, StDone} state_e;

    localparam logic [3:0] WaitLast = 4'(TIMEOUT - 1);

    state_e     state;
    logic [3:0] wait_cnt;
    logic       owner;
    logic       grant0;
    logic       grant1;

`ifdef MULT32X32_ARB_RR_EN
    logic prio;

    // prio names the port that wins a tie
    always_comb begin
        grant0 = req0_valid && (!req1_valid || !prio);
        grant1 = req1_valid && (!req0_valid || prio);
    end
`else
    always_comb begin
        grant0 = req0_valid;
        grant1 = req1_valid && !req0_valid;
    end
`endif

    assign req0_ready = (state == StIdle) && grant0;
    assign req1_ready = (state == StIdle) && grant1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= StIdle;
            wait_cnt    <= '0;
            owner       <= 1'b0;
            mult_start  <= 1'b0;
            mult_a      <= '0;
            mult_b      <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= 1'b0;
            rsp_product <= '0;
            rsp_err     <= 1'b0;
`ifdef MULT32X32_ARB_RR_EN
            prio        <= 1'b0;
`endif
        end else begin
            mult_start <= 1'b0;
            rsp_valid  <= 1'b0;
            case (state)
                StIdle: begin
                    if (grant0 || grant1) begin
                        mult_a <= grant1 ? req1_a : req0_a;
                        mult_b <= grant1 ? req1_b : req0_b;
                        owner  <= grant1;
                        state  <= StStart;
                    end
                end
                StStart: begin
                    mult_start <= 1'b1;
                    wait_cnt   <= '0;
                    state      <= StWaitBusy;
                end
                StWaitBusy: begin
                    if (mult_busy) begin
                        state <= StRun;
                    end else if (wait_cnt == WaitLast) begin
                        rsp_err     <= 1'b1;
                        rsp_product <= '0;
                        state       <= StDone;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                StRun: begin
                    if (!mult_busy) begin
                        rsp_product <= mult_product;
                        rsp_err     <= 1'b0;
                        state       <= StDone;
                    end
                end
                StDone: begin
                    rsp_valid <= 1'b1;
                    rsp_id    <= owner;
`ifdef MULT32X32_ARB_RR_EN
                    prio      <= !owner;
`endif
                    state     <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
